// File: rtl/ora_misr.sv
// Output response analyzer: compacts CUT responses into a MISR and, at session
// end, compares the final signature against a golden value.
module ora_misr #(
   parameter int            BITS   = 4,
   parameter logic [BITS-1:0] POLY   = 4'b0011,
   parameter logic [BITS-1:0] SEED   = '0,
   parameter logic [BITS-1:0] GOLDEN = 4'hA,
   parameter int            CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             en,
   input  logic             test_end,
   input  logic [BITS-1:0]  response,
   output logic [BITS-1:0]  signature,
   output logic [CNT_W-1:0] pattern_count,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [BITS-1:0]  r_sig;
   logic [CNT_W-1:0] r_count;
   logic             r_done;
   logic             r_pass;

   logic [BITS-1:0]  w_sig_next;
   logic             w_msb;

   // One MISR step: shift up, inject the MSB at tapped stages, XOR in the response.
   always_comb begin
      w_msb         = r_sig[BITS-1];
      w_sig_next    = '0;
      w_sig_next[0] = (POLY[0] & w_msb) ^ response[0];
      for (int i = 1; i < BITS; i++) begin
         w_sig_next[i] = r_sig[i-1] ^ (POLY[i] & w_msb) ^ response[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_sig   <= SEED;
         r_count <= '0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state <= RUN;
                  r_sig   <= SEED;
                  r_count <= '0;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            RUN: begin
               if (start) begin
                  r_sig   <= SEED;
                  r_count <= '0;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end else begin
                  // A response arriving with test_end is still the last pattern.
                  if (en) begin
                     r_sig <= w_sig_next;
                     if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + 1'b1;
                     end
                  end
                  if (test_end) begin
                     r_state <= CHECK;
                  end
               end
            end
            CHECK: begin
               r_pass  <= (r_sig == GOLDEN);
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign signature     = r_sig;
   assign pattern_count = r_count;
   assign busy          = (r_state == RUN) || (r_state == CHECK);
   assign done          = r_done;
   assign pass          = r_pass;

endmodule

// File: tb/tb_ora_misr.sv
// Directed self-checking bench for ora_misr with hand-computed MISR signatures
// (x^4+x+1, seed 0, golden 4'hA).
module tb_ora_misr;

   logic        clk;
   logic        rst;
   logic        start;
   logic        en;
   logic        test_end;
   logic [3:0]  response;
   logic [3:0]  signature;
   logic [15:0] pattern_count;
   logic        busy;
   logic        done;
   logic        pass;

   int checks;
   int failures;

   ora_misr dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .en            (en),
      .test_end      (test_end),
      .response      (response),
      .signature     (signature),
      .pattern_count (pattern_count),
      .busy          (busy),
      .done          (done),
      .pass          (pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs on the falling edge, then return 1ns after the next rising edge.
   task automatic step(input logic s, input logic e, input logic te, input logic [3:0] r);
      @(negedge clk);
      start    = s;
      en       = e;
      test_end = te;
      response = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0; en = 1'b0; test_end = 1'b0; response = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (signature !== 4'h0 || pattern_count !== 16'd0 || busy !== 1'b0 ||
          done !== 1'b0 || pass !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state: sig=%h cnt=%0d busy=%b done=%b pass=%b, required sig=0 cnt=0 busy=0 done=0 pass=0",
                  signature, pattern_count, busy, done, pass);
      end
      step(1'b0, 1'b1, 1'b1, 4'hF);
      step(1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (signature !== 4'h0 || pattern_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_ignores_en: sig=%h cnt=%0d busy=%b done=%b, required sig=0 cnt=0 busy=0 done=0",
                  signature, pattern_count, busy, done);
      end
   endtask

   task automatic test_golden_pass();
      logic [3:0] expSig [4];
      expSig[0] = 4'hF; expSig[1] = 4'h2; expSig[2] = 4'hB; expSig[3] = 4'hA;
      step(1'b1, 1'b0, 1'b0, 4'h0);
      checks++;
      if (busy !== 1'b1 || signature !== 4'h0) begin
         failures++;
         $display("[TB] FAIL golden_start: busy=%b sig=%h, required busy=1 sig=0", busy, signature);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, (i == 3), 4'hF);
         checks++;
         if (signature !== expSig[i]) begin
            failures++;
            $display("[TB] FAIL golden_sig_%0d: sig=%h, required %h", i, signature, expSig[i]);
         end
      end
      checks++;
      if (pattern_count !== 16'd4 || busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL golden_check_state: cnt=%0d busy=%b done=%b, required cnt=4 busy=1 done=0",
                  pattern_count, busy, done);
      end
      step(1'b0, 1'b1, 1'b1, 4'h5);
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || signature !== 4'hA || pattern_count !== 16'd4) begin
         failures++;
         $display("[TB] FAIL golden_result: done=%b pass=%b busy=%b sig=%h cnt=%0d, required done=1 pass=1 busy=0 sig=a cnt=4",
                  done, pass, busy, signature, pattern_count);
      end
      step(1'b0, 1'b1, 1'b1, 4'h7);
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || signature !== 4'hA || pattern_count !== 16'd4) begin
         failures++;
         $display("[TB] FAIL done_hold: done=%b pass=%b sig=%h cnt=%0d, required done=1 pass=1 sig=a cnt=4",
                  done, pass, signature, pattern_count);
      end
   endtask

   task automatic test_restart_from_done();
      step(1'b1, 1'b1, 1'b0, 4'hF);
      checks++;
      if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 || signature !== 4'h0 || pattern_count !== 16'd0) begin
         failures++;
         $display("[TB] FAIL restart_from_done: done=%b pass=%b busy=%b sig=%h cnt=%0d, required done=0 pass=0 busy=1 sig=0 cnt=0",
                  done, pass, busy, signature, pattern_count);
      end
   endtask

   task automatic test_fail_detect();
      logic [3:0] resp [4];
      resp[0] = 4'hF; resp[1] = 4'hE; resp[2] = 4'hF; resp[3] = 4'hF;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, (i == 3), resp[i]);
      end
      checks++;
      if (signature !== 4'hE || pattern_count !== 16'd4) begin
         failures++;
         $display("[TB] FAIL faulty_sig: sig=%h cnt=%0d, required sig=e cnt=4", signature, pattern_count);
      end
      step(1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         failures++;
         $display("[TB] FAIL faulty_result: done=%b pass=%b, required done=1 pass=0", done, pass);
      end
   endtask

   task automatic test_zero_gaps();
      step(1'b1, 1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 4'hF);
      step(1'b0, 1'b1, 1'b0, 4'h0);
      checks++;
      if (signature !== 4'h0 || pattern_count !== 16'd2) begin
         failures++;
         $display("[TB] FAIL zero_gaps: sig=%h cnt=%0d, required sig=0 cnt=2", signature, pattern_count);
      end
      step(1'b0, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || pattern_count !== 16'd2) begin
         failures++;
         $display("[TB] FAIL zero_result: done=%b pass=%b cnt=%0d, required done=1 pass=0 cnt=2",
                  done, pass, pattern_count);
      end
   endtask

   task automatic test_start_priority();
      step(1'b1, 1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 1'b0, 4'hF);
      step(1'b0, 1'b1, 1'b0, 4'hF);
      step(1'b1, 1'b1, 1'b1, 4'hF);
      checks++;
      if (signature !== 4'h0 || pattern_count !== 16'd0 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL start_priority: sig=%h cnt=%0d busy=%b, required sig=0 cnt=0 busy=1",
                  signature, pattern_count, busy);
      end
      step(1'b0, 1'b1, 1'b0, 4'hF);
      checks++;
      if (signature !== 4'hF || pattern_count !== 16'd1 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL after_restart: sig=%h cnt=%0d busy=%b, required sig=f cnt=1 busy=1",
                  signature, pattern_count, busy);
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 1'b0, 4'hF);
      step(1'b0, 1'b1, 1'b0, 4'hF);
      checks++;
      if (signature !== 4'h2 || pattern_count !== 16'd2) begin
         failures++;
         $display("[TB] FAIL pre_reset: sig=%h cnt=%0d, required sig=2 cnt=2", signature, pattern_count);
      end
      en = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (signature !== 4'h0 || pattern_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset: sig=%h cnt=%0d busy=%b done=%b, required sig=0 cnt=0 busy=0 done=0",
                  signature, pattern_count, busy, done);
      end
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b1, 4'hF);
      step(1'b0, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || signature !== 4'h0 || pattern_count !== 16'd0) begin
         failures++;
         $display("[TB] FAIL post_reset_idle: done=%b busy=%b sig=%h cnt=%0d, required done=0 busy=0 sig=0 cnt=0",
                  done, busy, signature, pattern_count);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_golden_pass();
      test_restart_from_done();
      test_fail_detect();
      test_zero_gaps();
      test_start_priority();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
